// File: rtl/input_replay.sv
// input_replay: timed button-event replay plus SM510 K-line matrix mapper.
// Define INPUT_REPLAY_LOOP_EN to wrap from the last event back to event 0.
module input_replay #(
   parameter int BUTTONS = 8,
   parameter int EVENTS  = 16,
   parameter int DELTA_W = 20,
   localparam int EAW = $clog2(EVENTS),
   localparam int BAW = $clog2(BUTTONS),
   localparam int EDW = DELTA_W + 2*BUTTONS + 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               step,
   input  logic               start,
   input  logic               evt_wr_en,
   input  logic [EAW-1:0]     evt_wr_addr,
   input  logic [EDW-1:0]     evt_wr_data,
   input  logic               map_wr_en,
   input  logic [BAW-1:0]     map_wr_addr,
   input  logic [6:0]         map_wr_data,
   input  logic [7:0]         shifter_s,
   input  logic [3:0]         output_r,
   output logic [BUTTONS-1:0] buttons,
   output logic [3:0]         input_k,
   output logic               busy,
   output logic               done,
   output logic               fired,
   output logic [EAW-1:0]     event_idx
);

   localparam int STROBES = 12;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_LOAD  = 2'd1;
   localparam logic [1:0] S_COUNT = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]         state_q, state_d;
   logic [EDW-1:0]     tbl_q [EVENTS];
   logic [6:0]         map_q [BUTTONS];
   logic [EAW-1:0]     idx_q, idx_d;
   logic [DELTA_W-1:0] cnt_q, cnt_d, delta_q;
   logic [BUTTONS-1:0] set_q, clr_q, btn_q, btn_d;
   logic               stop_q, fired_q, fired_d;
   logic [3:0]         k_q, k_d;
   logic [STROBES-1:0] src;
   logic [15:0]        strobes;
   logic               hit;

   // Unused strobe indices 12..15 read as zero so they never match.
   assign src     = {output_r, shifter_s};
   assign strobes = 16'(src);
   assign hit     = (state_q == S_COUNT) && (cnt_q >= delta_q);

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      btn_d   = btn_q;
      fired_d = 1'b0;
      if (step && (state_q == S_LOAD || state_q == S_COUNT) && !(&cnt_q))
         cnt_d = cnt_q + DELTA_W'(1);
      if (state_q == S_LOAD) begin
         cnt_d    = '0;
         cnt_d[0] = step;
         state_d  = S_COUNT;
      end
      if (hit) begin
         btn_d   = (btn_q & ~clr_q) | set_q;
         fired_d = 1'b1;
`ifdef INPUT_REPLAY_LOOP_EN
         if (stop_q) begin
            state_d = S_DONE;
         end else begin
            idx_d   = idx_q + EAW'(1);
            state_d = S_LOAD;
         end
`else
         if (stop_q || idx_q == EAW'(EVENTS - 1)) begin
            state_d = S_DONE;
         end else begin
            idx_d   = idx_q + EAW'(1);
            state_d = S_LOAD;
         end
`endif
      end
      if (start) begin
         btn_d   = '0;
         cnt_d   = '0;
         idx_d   = '0;
         fired_d = 1'b0;
         state_d = S_LOAD;
      end
   end

   always_comb begin
      k_d = '0;
      for (int i = 0; i < BUTTONS; i++) begin
         if (btn_q[i] && map_q[i][6] && strobes[map_q[i][5:2]])
            k_d[map_q[i][1:0]] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         cnt_q   <= '0;
         btn_q   <= '0;
         fired_q <= 1'b0;
         k_q     <= '0;
         delta_q <= '0;
         set_q   <= '0;
         clr_q   <= '0;
         stop_q  <= 1'b0;
         for (int i = 0; i < EVENTS; i++) tbl_q[i] <= '0;
         for (int i = 0; i < BUTTONS; i++) map_q[i] <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         btn_q   <= btn_d;
         fired_q <= fired_d;
         k_q     <= k_d;
         // Working copy isolates the running event from table rewrites.
         if (state_q == S_LOAD)
            {stop_q, clr_q, set_q, delta_q} <= tbl_q[idx_q];
         if (evt_wr_en) tbl_q[evt_wr_addr] <= evt_wr_data;
         if (map_wr_en) map_q[map_wr_addr] <= map_wr_data;
      end
   end

   assign buttons   = btn_q;
   assign input_k   = k_q;
   assign busy      = (state_q == S_LOAD) || (state_q == S_COUNT);
   assign done      = (state_q == S_DONE);
   assign fired     = fired_q;
   assign event_idx = idx_q;

endmodule

// File: tb/tb_input_replay.sv
// Directed bench for input_replay: replay timing, key mapping, start/reset aborts.
// Loop-mode expectations follow INPUT_REPLAY_LOOP_EN.
module tb_input_replay;

   localparam int B   = 8;
   localparam int E   = 4;
   localparam int DW  = 20;
   localparam int EDW = DW + 2*B + 1;

   logic           clk = 1'b0;
   logic           reset, step, start, evt_wr_en, map_wr_en;
   logic [1:0]     evt_wr_addr;
   logic [EDW-1:0] evt_wr_data;
   logic [2:0]     map_wr_addr;
   logic [6:0]     map_wr_data;
   logic [7:0]     shifter_s;
   logic [3:0]     output_r;
   logic [B-1:0]   buttons;
   logic [3:0]     input_k;
   logic           busy, done, fired;
   logic [1:0]     event_idx;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   input_replay #(.BUTTONS(B), .EVENTS(E), .DELTA_W(DW)) dut (
      .clk(clk), .reset(reset), .step(step), .start(start),
      .evt_wr_en(evt_wr_en), .evt_wr_addr(evt_wr_addr),
      .evt_wr_data(evt_wr_data), .map_wr_en(map_wr_en),
      .map_wr_addr(map_wr_addr), .map_wr_data(map_wr_data),
      .shifter_s(shifter_s), .output_r(output_r), .buttons(buttons),
      .input_k(input_k), .busy(busy), .done(done), .fired(fired),
      .event_idx(event_idx)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr_evt(input int a, input logic stp, input logic [7:0] clr,
                         input logic [7:0] set, input logic [19:0] d);
      evt_wr_en   = 1'b1;
      evt_wr_addr = 2'(a);
      evt_wr_data = {stp, clr, set, d};
      tick();
      evt_wr_en   = 1'b0;
   endtask

   task automatic wr_map(input int a, input logic [3:0] s, input logic [1:0] k);
      map_wr_en   = 1'b1;
      map_wr_addr = 3'(a);
      map_wr_data = {1'b1, s, k};
      tick();
      map_wr_en   = 1'b0;
   endtask

   task automatic go();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   initial begin
      int n;
      logic [7:0] eb [8];
      logic [1:0] eidx [6];
      logic       edone [6];
      eb = '{8'h00, 8'h01, 8'h01, 8'h03, 8'h03, 8'h07, 8'h07, 8'h0F};
`ifdef INPUT_REPLAY_LOOP_EN
      eidx  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
      edone = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`else
      eidx  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
      edone = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
`endif
      reset = 1'b1; step = 1'b0; start = 1'b0;
      evt_wr_en = 1'b0; evt_wr_addr = '0; evt_wr_data = '0;
      map_wr_en = 1'b0; map_wr_addr = '0; map_wr_data = '0;
      shifter_s = 8'hFF; output_r = 4'hF;
      tick(); tick();
      reset = 1'b0;
      for (int i = 0; i < 100; i++) begin
         tick();
         chk("idle_after_reset",
             32'({buttons, input_k, busy, done, fired, event_idx}), 32'd0);
      end

      // long-delta set then clear with stop
      wr_evt(0, 1'b0, 8'h00, 8'h04, 20'h8000);
      wr_evt(1, 1'b1, 8'h04, 8'h00, 20'h00800);
      wr_map(2, 4'd2, 2'd2);
      shifter_s = 8'h04; output_r = 4'h0;
      step = 1'b1;
      go();
      chk("busy_load", 32'(busy), 32'd1);
      chk("idx_start", 32'(event_idx), 32'd0);
      n = 0;
      while (!buttons[2] && n < 36864) begin
         tick();
         n++;
      end
      chk("set_edge", 32'(n), 32'h8001);
      chk("k_lags", 32'(input_k), 32'd0);
      chk("fired_set", 32'(fired), 32'd1);
      chk("idx_after_set", 32'(event_idx), 32'd1);
      tick();
      chk("k_on", 32'(input_k), 32'h4);
      n = 1;
      while (buttons[2] && n < 8192) begin
         tick();
         n++;
      end
      chk("clr_edge", 32'(n), 32'h801);
      chk("done_stop", 32'(done), 32'd1);
      chk("busy_stop", 32'(busy), 32'd0);
      chk("idx_stop", 32'(event_idx), 32'd1);
      tick();
      chk("k_off", 32'(input_k), 32'd0);
      step = 1'b0; shifter_s = 8'h00;

      // two buttons sharing k0 via strobes 1 and 9
      wr_map(0, 4'd1, 2'd0);
      wr_map(1, 4'd9, 2'd0);
      wr_evt(0, 1'b1, 8'h00, 8'h03, 20'd0);
      go();
      tick(); tick();
      chk("map_buttons", 32'(buttons), 32'h03);
      chk("map_done", 32'(done), 32'd1);
      for (int v = 0; v < 4; v++) begin
         shifter_s = {6'b0, v[0], 1'b0};
         output_r  = {2'b0, v[1], 1'b0};
         tick();
         chk("kmap", 32'(input_k), 32'(v[0] | v[1]));
      end
      shifter_s = 8'h01; output_r = 4'h1;
      tick();
      chk("kmap_decoy", 32'(input_k), 32'd0);
      shifter_s = 8'hFD; output_r = 4'hD;
      tick();
      chk("kmap_others", 32'(input_k), 32'd0);
      shifter_s = 8'h00; output_r = 4'h0;

      // back-to-back delta-0 events
      wr_evt(0, 1'b0, 8'h00, 8'h01, 20'd0);
      wr_evt(1, 1'b0, 8'h00, 8'h02, 20'd0);
      wr_evt(2, 1'b0, 8'h00, 8'h04, 20'd0);
      wr_evt(3, 1'b1, 8'h00, 8'h08, 20'd0);
      go();
      for (int k = 1; k <= 8; k++) begin
         tick();
         chk("b2b_buttons", 32'(buttons), 32'(eb[k-1]));
         chk("b2b_fired", 32'(fired), 32'(k % 2 == 0));
      end
      chk("b2b_done", 32'(done), 32'd1);

      // set wins over clear
      wr_evt(0, 1'b1, 8'h01, 8'h01, 20'd0);
      go();
      tick(); tick();
      chk("set_wins", 32'(buttons), 32'h01);

      // start mid-COUNT on event 3
      wr_evt(0, 1'b0, 8'h00, 8'h01, 20'd0);
      wr_evt(3, 1'b1, 8'h00, 8'h08, 20'd100);
      shifter_s = 8'h02;
      go();
      for (int k = 0; k < 7; k++) tick();
      chk("mid_idx", 32'(event_idx), 32'd3);
      chk("mid_buttons", 32'(buttons), 32'h07);
      chk("mid_k", 32'(input_k), 32'd1);
      go();
      chk("restart_buttons", 32'(buttons), 32'd0);
      chk("restart_idx", 32'(event_idx), 32'd0);
      chk("restart_busy", 32'({busy, done, fired}), 32'b100);
      tick(); tick();
      chk("restart_fire", 32'(buttons), 32'h01);

      // reset mid-COUNT
      for (int k = 0; k < 5; k++) tick();
      chk("pre_reset_idx", 32'(event_idx), 32'd3);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("mid_reset",
          32'({buttons, input_k, busy, done, fired, event_idx}), 32'd0);
      wr_evt(0, 1'b1, 8'h00, 8'h03, 20'd0);
      shifter_s = 8'hFF; output_r = 4'hF;
      go();
      tick(); tick();
      chk("post_reset_buttons", 32'(buttons), 32'h03);
      tick();
      chk("map_cleared", 32'(input_k), 32'd0);

      // last-event behaviour, no stop bits
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int i = 0; i < 4; i++) wr_evt(i, 1'b0, 8'h00, 8'h00, 20'd0);
      go();
      for (int k = 1; k <= 11; k++) begin
         tick();
         if (k % 2 == 1) begin
            chk("seq_idx", 32'(event_idx), 32'(eidx[k/2]));
            chk("seq_done", 32'(done), 32'(edone[k/2]));
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/input_replay.md
# input_replay

Parametrised scripted-input sequencer and key-matrix mapper for the SM510-family CPU cores. It replays a programmable table of timed button events, counted in retired CPU instructions, and drives a button vector. It maps that vector onto the CPU `input_k` lines using the strobes the CPU itself drives (`shifter_s`, `output_r`). It replaces per-game hard-coded key matrices and step-count press scripts, and works both in simulation and on hardware for attract/regression playback.

## Interface
- `BUTTONS`, default 8: number of logical buttons; maximum 16.
- `EVENTS`, default 16: event table depth; power of two.
- `DELTA_W`, default 20: width of the per-event step delta.
- `STROBES`, fixed 12: strobe sources. Index 0-7 = `shifter_s[7:0]`, index 8-11 = `output_r[3:0]`.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `step` in 1: one-cycle pulse per retired CPU instruction.
- `start` in 1: begin replay at event 0.
- `evt_wr_en` in 1: event table write strobe.
- `evt_wr_addr` in log2(EVENTS): event table write address.
- `evt_wr_data` in DELTA_W+2*BUTTONS+1: fields `{stop, clr_mask, set_mask, delta}`.
- `map_wr_en` in 1: map write strobe.
- `map_wr_addr` in log2(BUTTONS): button index to map.
- `map_wr_data` in 7: fields `{valid, strobe_idx[3:0], k_bit[1:0]}`.
- `shifter_s` in 8: CPU shifter strobes.
- `output_r` in 4: CPU R strobes.
- `buttons` out BUTTONS: current button state.
- `input_k` out 4: K lines to the CPU.
- `busy` out 1: replay in progress.
- `done` out 1: replay finished.
- `fired` out 1: one-cycle pulse when an event is applied.
- `event_idx` out log2(EVENTS): index of the current event.

## Operation
- States: IDLE, LOAD, COUNT, DONE.
- IDLE: entered on reset.
- `start` in any state:
  - clears `buttons` and the step counter;
  - sets `event_idx`=0;
  - next state LOAD.
  - `start` overrides every other transition in the same cycle.
- LOAD:
  - registered read of `table[event_idx]` into the working registers;
  - clears the step counter;
  - next state COUNT.
- Step counter:
  - counts `step` pulses in LOAD and COUNT;
  - saturates at all-ones;
  - a pulse in the clearing LOAD cycle is counted; the counter ends LOAD at 1 if `step` was high.
- COUNT, when counter >= delta, the event fires:
  - `buttons` <= (`buttons` & ~`clr_mask`) | `set_mask`, so set wins over clear on the same bit;
  - `fired` pulses;
  - if `stop`=1, or `event_idx`=EVENTS-1, next state DONE;
  - otherwise `event_idx` increments and next state is LOAD.
- DONE: `buttons` hold; `done`=1; only `start` or `reset` leave this state.
- Outputs by state: `busy`=1 in LOAD and COUNT. `done`=1 only in DONE.
- Table writes:
  - accepted in any state;
  - a write to the entry currently held in the working registers does not affect the running event;
  - writes to later entries take effect when those entries are loaded.
- Map writes: accepted in any state; effective from the next cycle.
- `input_k` is registered every cycle. Bit b is 1 when some button i has all of:
  - `buttons[i]`=1;
  - `map[i].valid`=1;
  - `map[i].k_bit`=b;
  - the strobe selected by `map[i].strobe_idx` is 1.
- `strobe_idx` > 11 never matches.
- Reset values:
  - state IDLE;
  - `buttons`=0, `input_k`=0, `busy`=0, `done`=0, `fired`=0, `event_idx`=0;
  - event table and map cleared (`valid`=0, all fields 0).
- Reset mid-replay aborts immediately with the same result.

## Timing
- `start` is sampled at edge E0. LOAD occupies E0→E1 and COUNT begins at E1.
- A delta-0 event updates `buttons` at E2. `fired` is high E2→E3.
- Back-to-back delta-0 events apply every 2 cycles.
- An event with delta=N applies on the edge after the cycle in which the counter reaches N. This is ≥ 1 cycle after the Nth `step` pulse.
- `input_k` lags `buttons` and the strobes by 1 cycle.

## Configuration
- `INPUT_REPLAY_LOOP_EN` defined:
  - after the last event (index EVENTS-1) fires without `stop`, `event_idx` wraps to 0 and the next state is LOAD;
  - `done` is only reached via `stop`.
- `INPUT_REPLAY_LOOP_EN` undefined: the last event always goes to DONE.
- `stop` semantics are identical in both builds.

## Test plan
- Reset with table and map empty, strobes all 1 → `buttons`=0, `input_k`=0, `busy`=0, `done`=0 for 100 cycles.
- Event 0 = {set button 2, delta 0x8000}, event 1 = {clr button 2, delta 0x800, stop}; map button 2 → {valid, strobe 2, k_bit 2}; `shifter_s`=0x04; start, then step every 4 cycles:
  - `buttons[2]` rises after the 0x8000th step;
  - `input_k`=0x4 one cycle later;
  - `buttons[2]` clears after a further 0x800 steps;
  - `done`=1, `busy`=0.
- Map buttons 0 and 1 both to k_bit 0 on strobes 1 and 9; press both, toggle `shifter_s[1]` and `output_r[1]` independently → `input_k[0]`=1 exactly when a matching strobe is high.
- Four events with delta 0, set_mask 1, 2, 4, 8 → `fired` pulses 2 cycles apart; `buttons` steps 0x1, 0x3, 0x7, 0xF.
- Same event with set_mask=clr_mask=0x1 → `buttons[0]`=1.
- Assert `start` mid-COUNT on event 3 → `buttons`=0 next cycle, `event_idx`=0, state LOAD.
- Assert `reset` mid-COUNT → all outputs at reset values next cycle.
- With `INPUT_REPLAY_LOOP_EN`, EVENTS=4, no stop bits → `event_idx` sequence 0,1,2,3,0,1; `done` stays 0.
- Without `INPUT_REPLAY_LOOP_EN`, same table → `done`=1 after event 3.
